seg_timer_ctrl: RTL and testbench

SEG_TIMER_CTRL -- requirements
Module: seg_timer_ctrl

---
 rtl/seg_timer_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_timer_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_timer_ctrl.sv
// Two-digit BCD up/down seconds timer with run/pause/clear/preset control.
// Ports: clk, rst_n, start_pulse, clear_pulse, dir, load_en, load_tens,
//   load_units in; seg_data_1 (tens), seg_data_2 (units), seg_blank,
//   running, done out. TICK_DIV clk cycles per count tick.
module seg_timer_ctrl #(
  parameter int unsigned TICK_DIV = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_pulse,
  input  logic       clear_pulse,
  input  logic       dir,
  input  logic       load_en,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] seg_data_1,
  output logic [3:0] seg_data_2,
  output logic       seg_blank,
  output logic       running,
  output logic       done
);

  localparam logic [23:0] PMAX = 24'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic [23:0] presc_q, presc_d;
  logic        dir_q, dir_d;
  logic        blank_q, blank_d;
  logic        running_q, done_q;

  logic        tick;
  logic [23:0] presc_nx;
  logic [3:0]  step_t, step_u;
  logic        last;
  logic        at_top, at_bot;

  always_comb begin
    tick     = (presc_q == PMAX);
    presc_nx = tick ? 24'd0 : presc_q + 24'd1;
    at_top   = (tens_q == 4'd9) && (units_q == 4'd9);
    at_bot   = (tens_q == 4'd0) && (units_q == 4'd0);
    step_t   = tens_q;
    step_u   = units_q;
    if (dir_q) begin
      if (units_q == 4'd0) begin
        step_u = 4'd9;
        step_t = tens_q - 4'd1;
      end else begin
        step_u = units_q - 4'd1;
      end
      last = (tens_q == 4'd0) && (units_q == 4'd1);
    end else begin
      if (units_q == 4'd9) begin
        step_u = 4'd0;
        step_t = tens_q + 4'd1;
      end else begin
        step_u = units_q + 4'd1;
      end
      last = (tens_q == 4'd9) && (units_q == 4'd8);
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    blank_d = blank_q;
    if (clear_pulse) begin
      state_d = IDLE;
      tens_d  = 4'd0;
      units_d = 4'd0;
      presc_d = 24'd0;
      blank_d = 1'b0;
    end else if (load_en && state_q == IDLE) begin
      tens_d  = (load_tens > 4'd9) ? 4'd9 : load_tens;
      units_d = (load_units > 4'd9) ? 4'd9 : load_units;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_pulse) begin
            dir_d   = dir;
            presc_d = 24'd0;
            state_d = (dir ? at_bot : at_top) ? DONE : RUN;
          end
        end
        RUN: begin
          presc_d = presc_nx;
          // A tick that lands on the terminal value wins over a pause request.
          if (tick) begin
            tens_d  = step_t;
            units_d = step_u;
          end
          if (tick && last) state_d = DONE;
          else if (start_pulse) state_d = PAUSE;
        end
        PAUSE: begin
          if (start_pulse) state_d = RUN;
        end
        DONE: begin
          presc_d = presc_nx;
          if (tick) blank_d = ~blank_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      presc_q   <= 24'd0;
      dir_q     <= 1'b0;
      blank_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      blank_q   <= blank_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign seg_data_1 = tens_q;
  assign seg_data_2 = units_q;
  assign seg_blank  = blank_q;
  assign running    = running_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seg_timer_ctrl.sv
// Bench for seg_timer_ctrl: directed scenarios plus random control traffic
// checked every cycle against an integer-count reference model.
module tb_seg_timer_ctrl;

  localparam int TD = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_pulse = 1'b0;
  logic       clear_pulse = 1'b0;
  logic       dir = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_units = 4'd0;
  logic [3:0] seg_data_1, seg_data_2;
  logic       seg_blank, running, done;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  int m_pre = 0;
  int m_st = S_IDLE;
  int m_dir = 0;
  int m_blank = 0;

  seg_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_pulse(start_pulse), .clear_pulse(clear_pulse),
    .dir(dir), .load_en(load_en),
    .load_tens(load_tens), .load_units(load_units),
    .seg_data_1(seg_data_1), .seg_data_2(seg_data_2),
    .seg_blank(seg_blank), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clamp9(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_pre = 0; m_st = S_IDLE;
    m_dir = 0; m_blank = 0;
  endtask

  task automatic m_apply(input bit s, input bit c, input bit d,
                         input bit l, input int lt, input int lu);
    int term;
    bit tk;
    if (c) begin
      m_cnt = 0; m_pre = 0; m_blank = 0; m_st = S_IDLE;
    end else if (l && m_st == S_IDLE) begin
      m_cnt = clamp9(lt) * 10 + clamp9(lu);
    end else if (m_st == S_IDLE) begin
      if (s) begin
        m_dir = d;
        m_pre = 0;
        term = d ? 0 : 99;
        m_st = (m_cnt == term) ? S_DONE : S_RUN;
      end
    end else if (m_st == S_RUN) begin
      tk = (m_pre == TD - 1);
      m_pre = tk ? 0 : m_pre + 1;
      term = m_dir ? 0 : 99;
      if (tk) m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
      if (tk && m_cnt == term) m_st = S_DONE;
      else if (s) m_st = S_PAUSE;
    end else if (m_st == S_PAUSE) begin
      if (s) m_st = S_RUN;
    end else begin
      tk = (m_pre == TD - 1);
      m_pre = tk ? 0 : m_pre + 1;
      if (tk) m_blank = 1 - m_blank;
    end
  endtask

  task automatic cmp_model();
    chk("seg1", {4'd0, seg_data_1}, 8'(m_cnt / 10));
    chk("seg2", {4'd0, seg_data_2}, 8'(m_cnt % 10));
    chk("blank", {7'd0, seg_blank}, 8'(m_blank));
    chk("running", {7'd0, running}, 8'(m_st == S_RUN));
    chk("done", {7'd0, done}, 8'(m_st == S_DONE));
  endtask

  task automatic cyc(input bit s, input bit c, input bit d,
                     input bit l, input int lt, input int lu);
    @(negedge clk);
    start_pulse = s; clear_pulse = c; dir = d;
    load_en = l; load_tens = 4'(lt); load_units = 4'(lu);
    @(posedge clk);
    m_apply(s, c, d, l, lt, lu);
    #1;
    cmp_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [7:0] digs();
    return {seg_data_1, seg_data_2};
  endfunction

  initial begin
    m_reset();
    #1;
    chk("rst_digits", digs(), 8'h00);
    chk("rst_flags", {5'd0, seg_blank, running, done}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // count up from 00
    cyc(1, 0, 0, 0, 0, 0);
    chk("up_running", {7'd0, running}, 8'h01);
    idle(4);
    chk("up_01", digs(), 8'h01);
    idle(36);
    chk("up_10", digs(), 8'h10);
    cyc(0, 1, 0, 0, 0, 0);
    chk("clr_00", digs(), 8'h00);

    // already terminal: straight to DONE, blinking
    cyc(0, 0, 0, 1, 9, 9);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t99_done", {6'd0, running, done}, 8'h01);
    chk("t99_digits", digs(), 8'h99);
    idle(4);
    chk("blank_on", {7'd0, seg_blank}, 8'h01);
    idle(4);
    chk("blank_off", {7'd0, seg_blank}, 8'h00);
    cyc(1, 0, 0, 0, 0, 0);
    chk("done_ign_start", {7'd0, done}, 8'h01);
    cyc(0, 1, 0, 0, 0, 0);

    // clamp on load
    cyc(0, 0, 0, 1, 12, 15);
    chk("clamp_99", digs(), 8'h99);
    cyc(0, 1, 0, 0, 0, 0);

    // count down from 10 with a pause
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0, 0);
    idle(4);
    chk("dn_09", digs(), 8'h09);
    cyc(0, 0, 0, 1, 5, 5);
    chk("load_in_run", digs(), 8'h09);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0);
    idle(10);
    chk("pause_hold", digs(), 8'h09);
    chk("pause_flag", {7'd0, running}, 8'h00);
    cyc(1, 0, 0, 0, 0, 0);
    idle(100);
    chk("dn_00", digs(), 8'h00);
    chk("dn_done", {7'd0, done}, 8'h01);
    cyc(0, 1, 0, 0, 0, 0);

    // start on a tick cycle, then clear+start in RUN
    cyc(1, 0, 0, 0, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0);
    chk("tick_pause_dig", digs(), 8'h01);
    chk("tick_pause_st", {6'd0, running, done}, 8'h00);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("clr_start_dig", digs(), 8'h00);
    chk("clr_start_run", {7'd0, running}, 8'h00);

    // reset mid-RUN at 37
    cyc(0, 0, 0, 1, 3, 6);
    cyc(1, 0, 0, 0, 0, 0);
    idle(6);
    chk("pre_rst_37", digs(), 8'h37);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_mid_dig", digs(), 8'h00);
    chk("rst_mid_flags", {5'd0, seg_blank, running, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    chk("rst_no_tick", digs(), 8'h00);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 10) == 0, ($urandom % 150) == 0,
          1'($urandom), ($urandom % 12) == 0,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
